// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Memory-side bus of the shared CPU memory port: read/write strobes, address,
// write data with output enable, and the four-phase handshake returns.
//
// Signals:
//   readM       read strobe                (arbiter -> memory)
//   writeM      write strobe               (arbiter -> memory)
//   address     WORD_SIZE address          (arbiter -> memory)
//   mem_wdata   WORD_SIZE write data       (arbiter -> memory)
//   mem_oe      write-data bus enable      (arbiter -> memory)
//   mem_rdata   WORD_SIZE read data        (memory -> arbiter)
//   inputReady  read data valid            (memory -> arbiter)
//   ackOutput   write accepted             (memory -> arbiter)
//
// Modports: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_oe;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 inputReady;
    logic                 ackOutput;

    modport master (
        output readM,
        output writeM,
        output address,
        output mem_wdata,
        output mem_oe,
        input  mem_rdata,
        input  inputReady,
        input  ackOutput
    );

    modport slave (
        input  readM,
        input  writeM,
        input  address,
        input  mem_wdata,
        input  mem_oe,
        output mem_rdata,
        output inputReady,
        output ackOutput
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the CPU's single memory port between the instruction-fetch
// requester and the data load/store requester. Data has priority. Each access
// runs a four-phase handshake with memory and the port is only re-granted
// once both handshake returns are low again.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   f_req/f_addr             fetch request (level) and address
//   f_done/f_rdata           fetch complete pulse and fetched word
//   d_req/d_we/d_addr/d_wdata data request (level), store select, address, data
//   d_done/d_rdata           data complete pulse and loaded word
//   busy                     high whenever not IDLE
//   err                      timeout pulse, coincident with done
//   mem                      memory bus (mem_port_arbiter_if.master)
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that receives no
// handshake within TIMEOUT_CYCLES cycles (reads then return all ones).
//
// state | meaning
// IDLE  | port free, waiting for a request (data wins over fetch)
// RD    | readM asserted, waiting for inputReady
// WR    | writeM/mem_oe asserted, waiting for ackOutput
// REL   | strobe dropped, waiting for inputReady and ackOutput to fall
module mem_port_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [WORD_SIZE-1:0] f_addr,
    output logic                 f_done,
    output logic [WORD_SIZE-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 busy,
    output logic                 err,
    mem_port_arbiter_if.master   mem
);

    typedef enum logic [1:0] {IDLE, RD, WR, REL} state_t;

    state_t state;
    logic   owner_d;   // 1 = current access belongs to the data requester

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_r;

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner_d       <= 1'b0;
            f_done        <= 1'b0;
            f_rdata       <= '0;
            d_done        <= 1'b0;
            d_rdata       <= '0;
            busy          <= 1'b0;
            mem.readM     <= 1'b0;
            mem.writeM    <= 1'b0;
            mem.mem_oe    <= 1'b0;
            mem.address   <= '0;
            mem.mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt       <= '0;
            err_r         <= 1'b0;
`endif
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_r  <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (d_req) begin
                        owner_d     <= 1'b1;
                        busy        <= 1'b1;
                        mem.address <= d_addr;
                        if (d_we) begin
                            mem.writeM    <= 1'b1;
                            mem.mem_oe    <= 1'b1;
                            mem.mem_wdata <= d_wdata;
                            state         <= WR;
                        end else begin
                            mem.readM <= 1'b1;
                            state     <= RD;
                        end
                    end else if (f_req) begin
                        owner_d     <= 1'b0;
                        busy        <= 1'b1;
                        mem.address <= f_addr;
                        mem.readM   <= 1'b1;
                        state       <= RD;
                    end
                end

                RD: begin
                    if (mem.inputReady) begin
                        mem.readM <= 1'b0;
                        state     <= REL;
                        if (owner_d) begin
                            d_rdata <= mem.mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            f_rdata <= mem.mem_rdata;
                            f_done  <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        mem.readM <= 1'b0;
                        err_r     <= 1'b1;
                        state     <= REL;
                        if (owner_d) begin
                            d_rdata <= '1;
                            d_done  <= 1'b1;
                        end else begin
                            f_rdata <= '1;
                            f_done  <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                WR: begin
                    if (mem.ackOutput) begin
                        mem.writeM    <= 1'b0;
                        mem.mem_oe    <= 1'b0;
                        mem.mem_wdata <= '0;
                        d_done        <= 1'b1;
                        state         <= REL;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        mem.writeM    <= 1'b0;
                        mem.mem_oe    <= 1'b0;
                        mem.mem_wdata <= '0;
                        d_done        <= 1'b1;
                        err_r         <= 1'b1;
                        state         <= REL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                REL: begin
                    // No new grant until memory has released both handshakes.
                    if (!mem.inputReady && !mem.ackOutput) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table for the
// basic fetch and data-over-fetch arbitration, plus hand-written sequences for
// handshake hold in REL, request drop mid-access, reset mid-read and timeout.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_done;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16)) mem_bus ();

    mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_done  (f_done),
        .f_rdata (f_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .busy    (busy),
        .err     (err),
        .mem     (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] mem_rdata;
        logic        input_ready;
        logic        ack_output;
        logic        e_readM;
        logic        e_writeM;
        logic        e_mem_oe;
        logic [15:0] e_address;
        logic [15:0] e_mem_wdata;
        logic        e_f_done;
        logic        e_d_done;
        logic [15:0] e_f_rdata;
        logic [15:0] e_d_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " readM"},     16'(mem_bus.readM),  16'h0);
        check({tag, " writeM"},    16'(mem_bus.writeM), 16'h0);
        check({tag, " mem_oe"},    16'(mem_bus.mem_oe), 16'h0);
        check({tag, " address"},   mem_bus.address,     16'h0);
        check({tag, " mem_wdata"}, mem_bus.mem_wdata,   16'h0);
        check({tag, " f_done"},    16'(f_done),         16'h0);
        check({tag, " d_done"},    16'(d_done),         16'h0);
        check({tag, " f_rdata"},   f_rdata,             16'h0);
        check({tag, " d_rdata"},   d_rdata,             16'h0);
        check({tag, " busy"},      16'(busy),           16'h0);
        check({tag, " err"},       16'(err),            16'h0);
    endtask

    initial begin
        int wait_cnt;
        string tag;

        // inputs: f_req f_addr d_req d_we d_addr d_wdata mem_rdata inputReady ackOutput
        // expect: readM writeM mem_oe address mem_wdata f_done d_done f_rdata d_rdata busy
        // fetch 0x0003 returning 0x7320
        vecs[0]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[1]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7320, 1'b1, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h7320, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b0};
        // simultaneous store 0x000A -> 0x0020 and fetch 0x0040: store first
        vecs[5]  = '{1'b1, 16'h0040, 1'b1, 1'b1, 16'h0020, 16'h000A, 16'h0000, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 16'h0020, 16'h000A, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 16'h0040, 1'b1, 1'b1, 16'h0020, 16'h000A, 16'h0000, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h7320, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h7320, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0};

        reset = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_bus.mem_rdata = '0; mem_bus.inputReady = 1'b0; mem_bus.ackOutput = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            f_req                = vecs[i].f_req;
            f_addr               = vecs[i].f_addr;
            d_req                = vecs[i].d_req;
            d_we                 = vecs[i].d_we;
            d_addr               = vecs[i].d_addr;
            d_wdata              = vecs[i].d_wdata;
            mem_bus.mem_rdata    = vecs[i].mem_rdata;
            mem_bus.inputReady   = vecs[i].input_ready;
            mem_bus.ackOutput    = vecs[i].ack_output;
            step();
            tag = $sformatf("vec%0d", i);
            check({tag, " readM"},     16'(mem_bus.readM),  16'(vecs[i].e_readM));
            check({tag, " writeM"},    16'(mem_bus.writeM), 16'(vecs[i].e_writeM));
            check({tag, " mem_oe"},    16'(mem_bus.mem_oe), 16'(vecs[i].e_mem_oe));
            check({tag, " address"},   mem_bus.address,     vecs[i].e_address);
            check({tag, " mem_wdata"}, mem_bus.mem_wdata,   vecs[i].e_mem_wdata);
            check({tag, " f_done"},    16'(f_done),         16'(vecs[i].e_f_done));
            check({tag, " d_done"},    16'(d_done),         16'(vecs[i].e_d_done));
            check({tag, " f_rdata"},   f_rdata,             vecs[i].e_f_rdata);
            check({tag, " d_rdata"},   d_rdata,             vecs[i].e_d_rdata);
            check({tag, " busy"},      16'(busy),           16'(vecs[i].e_busy));
            check({tag, " err"},       16'(err),            16'h0);
        end

        // inputReady held after readM falls: stays in REL, no new strobe
        f_req = 1'b1; f_addr = 16'h0005;
        step();
        check("hold grant readM", 16'(mem_bus.readM), 16'h1);
        check("hold grant address", mem_bus.address, 16'h0005);
        mem_bus.inputReady = 1'b1; mem_bus.mem_rdata = 16'h00AA;
        step();
        check("hold f_done", 16'(f_done), 16'h1);
        check("hold f_rdata", f_rdata, 16'h00AA);
        check("hold readM low", 16'(mem_bus.readM), 16'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold rel%0d readM", k), 16'(mem_bus.readM), 16'h0);
            check($sformatf("hold rel%0d f_done", k), 16'(f_done), 16'h0);
            check($sformatf("hold rel%0d busy", k), 16'(busy), 16'h1);
        end
        mem_bus.inputReady = 1'b0;
        step();
        check("hold release busy", 16'(busy), 16'h0);
        check("hold release readM", 16'(mem_bus.readM), 16'h0);
        step();
        check("hold regrant readM", 16'(mem_bus.readM), 16'h1);
        mem_bus.inputReady = 1'b1; mem_bus.mem_rdata = 16'h0BEE;
        step();
        check("hold regrant f_done", 16'(f_done), 16'h1);
        check("hold regrant f_rdata", f_rdata, 16'h0BEE);
        f_req = 1'b0; mem_bus.inputReady = 1'b0;
        step();
        check("hold idle busy", 16'(busy), 16'h0);

        // load whose requester drops d_req one cycle after grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h001E;
        step();
        check("drop grant readM", 16'(mem_bus.readM), 16'h1);
        check("drop grant address", mem_bus.address, 16'h001E);
        d_req = 1'b0;
        step();
        check("drop readM kept", 16'(mem_bus.readM), 16'h1);
        check("drop d_done early", 16'(d_done), 16'h0);
        mem_bus.inputReady = 1'b1; mem_bus.mem_rdata = 16'h0005;
        step();
        check("drop d_done", 16'(d_done), 16'h1);
        check("drop d_rdata", d_rdata, 16'h0005);
        check("drop f_done", 16'(f_done), 16'h0);
        check("drop f_rdata kept", f_rdata, 16'h0BEE);
        mem_bus.inputReady = 1'b0;
        step();
        check("drop idle busy", 16'(busy), 16'h0);
        check("drop d_rdata hold", d_rdata, 16'h0005);

        // reset during a read
        f_req = 1'b1; f_addr = 16'h0009;
        step();
        check("rst grant readM", 16'(mem_bus.readM), 16'h1);
        reset = 1'b1; f_req = 1'b0;
        step();
        check_all_zero("rst mid-rd");
        reset = 1'b0;
        step();
        check("rst after busy", 16'(busy), 16'h0);
        check("rst after readM", 16'(mem_bus.readM), 16'h0);

        // read with no inputReady
        f_req = 1'b1; f_addr = 16'h0007;
        step();
        check("tmo grant readM", 16'(mem_bus.readM), 16'h1);
`ifdef MEM_TIMEOUT_EN
        wait_cnt = 0;
        do begin
            step();
            wait_cnt++;
        end while (!f_done && wait_cnt < 40);
        check("tmo f_done", 16'(f_done), 16'h1);
        check("tmo latency", 16'(wait_cnt), 16'd16);
        check("tmo err", 16'(err), 16'h1);
        check("tmo f_rdata", f_rdata, 16'hFFFF);
        check("tmo readM", 16'(mem_bus.readM), 16'h0);
        f_req = 1'b0;
        step();
        check("tmo err pulse", 16'(err), 16'h0);
        check("tmo idle busy", 16'(busy), 16'h0);
`else
        wait_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            wait_cnt++;
            check($sformatf("notmo c%0d readM", k), 16'(mem_bus.readM), 16'h1);
            check($sformatf("notmo c%0d err", k), 16'(err), 16'h0);
            check($sformatf("notmo c%0d f_done", k), 16'(f_done), 16'h0);
        end
        reset = 1'b1; f_req = 1'b0;
        step();
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
